// File: rtl/gauss_pkg.sv
// Shared types and defaults for the Gaussian filter frame controller.
package gauss_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int DIM_W_DEF     = 12;
  localparam int MAX_WIDTH_DEF = 1920;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // A frame is legal when both dimensions are non-zero and the width fits the line buffer.
  function automatic logic cfg_legal(input int unsigned w, input int unsigned h,
                                     input int unsigned max_w);
    return (w != 0) && (h != 0) && (w <= max_w);
  endfunction

endpackage

// File: rtl/gauss_pix_counter.sv
// Column/row position counter with width/height wrap and a last-pixel flag.
module gauss_pix_counter
  import gauss_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic [DIM_W-1:0] col,
  output logic [DIM_W-1:0] row,
  output logic             last
);

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  logic [DIM_W-1:0] col_reg, row_reg;
  logic             col_wrap, row_wrap;

  assign col_wrap = (col_reg == width - ONE);
  assign row_wrap = (row_reg == height - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (clr) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (inc) begin
      if (col_wrap) begin
        col_reg <= '0;
        row_reg <= row_wrap ? '0 : row_reg + ONE;
      end else begin
        col_reg <= col_reg + ONE;
      end
    end
  end

  assign col  = col_reg;
  assign row  = row_reg;
  assign last = col_wrap && row_wrap;

endmodule

// File: rtl/gauss_frame_ctrl.sv
// Frame sequencer in front of gaussianFilter: gates the pixel stream, injects a flush row, tracks outputs.
// Optional source-starvation counter enabled by defining GAUSS_CTRL_STALL_CNT_EN.
module gauss_frame_ctrl
  import gauss_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                DIM_W     = DIM_W_DEF,
  parameter int                MAX_WIDTH = MAX_WIDTH_DEF,
  parameter logic [DATA_W-1:0] PAD_VALUE = '0,
  parameter int                DRAIN_MAX = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DIM_W-1:0]   img_width,
  input  logic [DIM_W-1:0]   img_height,
  input  logic [DATA_W-1:0]  src_data,
  input  logic               src_valid,
  output logic               src_ready,
  output logic [DATA_W-1:0]  flt_data,
  output logic               flt_valid,
  output logic [DIM_W-1:0]   flt_width,
  input  logic               flt_out_valid,
  output logic               busy,
  output logic               frame_done,
  output logic               timeout,
  output logic               cfg_err,
  output logic [DIM_W-1:0]   col,
  output logic [DIM_W-1:0]   row,
  output logic [2*DIM_W-1:0] stall_cnt
);

  localparam int               CNT_W     = 2 * DIM_W;
  localparam int               TMR_W     = $clog2(DRAIN_MAX) + 1;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(DRAIN_MAX - 1);

  state_t             state_reg, state_next;
  logic [DIM_W-1:0]   width_reg, height_reg, flt_width_reg;
  logic [CNT_W-1:0]   expected_reg, out_cnt_reg;
  logic [TMR_W-1:0]   drain_tmr_reg;
  logic [DATA_W-1:0]  flt_data_reg;
  logic               flt_valid_reg, cfg_err_reg, timeout_reg;
  logic               start_ok, cfg_bad, xfer, flush_inc;
  logic               pix_last, flush_last, out_done, tmr_expired;
  logic [DIM_W-1:0]   flush_col, flush_row;
  logic               unused_flush;

  assign start_ok    = (state_reg == ST_IDLE) && start;
  assign cfg_bad     = !cfg_legal(32'(width_reg), 32'(height_reg), 32'(MAX_WIDTH));
  assign xfer        = src_ready && src_valid && !abort;
  assign flush_inc   = (state_reg == ST_FLUSH) && !abort;
  assign out_done    = (out_cnt_reg >= expected_reg);
  assign tmr_expired = (drain_tmr_reg == TMR_LIMIT);

  gauss_pix_counter #(.DIM_W(DIM_W)) u_pix_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_ok),
    .inc    (xfer),
    .width  (width_reg),
    .height (height_reg),
    .col    (col),
    .row    (row),
    .last   (pix_last)
  );

  // Same counter as a single-row sequence: its last flag marks the end of the flush row.
  gauss_pix_counter #(.DIM_W(DIM_W)) u_flush_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_ok),
    .inc    (flush_inc),
    .width  (width_reg),
    .height (DIM_W'(1)),
    .col    (flush_col),
    .row    (flush_row),
    .last   (flush_last)
  );

  assign unused_flush = &{1'b0, flush_col, flush_row};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:   if (start) state_next = ST_CHECK;
        ST_CHECK:  state_next = cfg_bad ? ST_IDLE : ST_STREAM;
        ST_STREAM: if (xfer && pix_last) state_next = ST_FLUSH;
        ST_FLUSH:  if (flush_last) state_next = ST_DRAIN;
        // Completion is tested before the timer so a tie resolves to DONE.
        ST_DRAIN: begin
          if (out_done)         state_next = ST_DONE;
          else if (tmr_expired) state_next = ST_IDLE;
        end
        ST_DONE:   state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    src_ready  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_reg)
      ST_IDLE:   busy = 1'b0;
      ST_STREAM: src_ready = 1'b1;
      ST_DONE:   frame_done = !abort;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_reg     <= '0;
      height_reg    <= '0;
      flt_width_reg <= '0;
      expected_reg  <= '0;
      out_cnt_reg   <= '0;
      drain_tmr_reg <= '0;
      flt_data_reg  <= '0;
      flt_valid_reg <= 1'b0;
      cfg_err_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      if (start_ok) begin
        width_reg  <= img_width;
        height_reg <= img_height;
      end
      if ((state_reg == ST_CHECK) && !cfg_bad && !abort) begin
        flt_width_reg <= width_reg;
      end
      if (state_reg == ST_CHECK) begin
        expected_reg <= CNT_W'(width_reg) * CNT_W'(height_reg);
      end
      // Saturating at expected keeps late extra outputs from wrapping the count.
      if (start_ok) begin
        out_cnt_reg <= '0;
      end else if ((state_reg != ST_IDLE) && flt_out_valid && !out_done) begin
        out_cnt_reg <= out_cnt_reg + CNT_W'(1);
      end
      drain_tmr_reg <= (state_reg == ST_DRAIN) ? drain_tmr_reg + TMR_W'(1) : '0;
      flt_valid_reg <= xfer || flush_inc;
      if (xfer) begin
        flt_data_reg <= src_data;
      end else if (flush_inc) begin
        flt_data_reg <= PAD_VALUE;
      end
      cfg_err_reg <= (state_reg == ST_CHECK) && cfg_bad && !abort;
      timeout_reg <= (state_reg == ST_DRAIN) && !abort && !out_done && tmr_expired;
    end
  end

  assign flt_data  = flt_data_reg;
  assign flt_valid = flt_valid_reg;
  assign flt_width = flt_width_reg;
  assign cfg_err   = cfg_err_reg;
  assign timeout   = timeout_reg;

`ifdef GAUSS_CTRL_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (start_ok) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == ST_STREAM) && !src_valid && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_gauss_frame_ctrl.sv
// Randomized self-checking bench for gauss_frame_ctrl with a behavioural frame model and filter stand-in.
module tb_gauss_frame_ctrl;

  localparam int                DATA_W    = 8;
  localparam int                DIM_W     = 12;
  localparam int                MAX_WIDTH = 1920;
  localparam logic [DATA_W-1:0] PAD       = 8'h00;
  localparam int                DRAIN_MAX = 64;
  localparam int                BUDGET    = 20000;

  logic               clk, rst_n, start, abort, src_valid, flt_out_valid;
  logic [DIM_W-1:0]   img_width, img_height, flt_width, col, row;
  logic [DATA_W-1:0]  src_data, flt_data;
  logic               src_ready, flt_valid, busy, frame_done, timeout, cfg_err;
  logic [2*DIM_W-1:0] stall_cnt;

  int tests_run = 0;
  int fail_cnt  = 0;

  gauss_frame_ctrl #(
    .DATA_W(DATA_W), .DIM_W(DIM_W), .MAX_WIDTH(MAX_WIDTH),
    .PAD_VALUE(PAD), .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .img_width(img_width), .img_height(img_height),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .flt_data(flt_data), .flt_valid(flt_valid), .flt_width(flt_width),
    .flt_out_valid(flt_out_valid), .busy(busy), .frame_done(frame_done),
    .timeout(timeout), .cfg_err(cfg_err), .col(col), .row(row), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // vmode: 0 valid always, 1 toggling from 1, 2 random. abort_t: abort when that many
  // transfers are done (-1 none). ign_scyc: stream cycle with a stray start (-1 none).
  task automatic run_frame(input int w, input int h, input int vmode, input int abort_t,
                           input int ign_scyc, input bit filt_on, input bit rand_data);
    int total, t, cyc, scyc, fin_cnt, flush_left, stall_exp;
    int end_cyc, entry_cyc, to_cyc, done_cnt, to_cnt, ce_cnt;
    bit stream_on, aborted, pend_v, v;
    logic [DATA_W-1:0] pend_d;
    total = w * h; t = 0; cyc = 0; scyc = 0; fin_cnt = 0; flush_left = 0; stall_exp = 0;
    end_cyc = BUDGET; entry_cyc = -1; to_cyc = -1; done_cnt = 0; to_cnt = 0; ce_cnt = 0;
    stream_on = 0; aborted = 0; pend_v = 0; pend_d = '0;
    @(negedge clk);
    start = 1; abort = 0; img_width = DIM_W'(w); img_height = DIM_W'(h);
    src_valid = 0; flt_out_valid = 0;
    while (cyc < end_cyc && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) stream_on = 1;
      if (cyc == 1) check_eq("busy_check", busy, 1);
      check_eq("src_ready", src_ready, stream_on);
      check_eq("flt_valid", flt_valid, pend_v);
      if (pend_v) check_eq("flt_data", flt_data, pend_d);
      if (stream_on) begin
        check_eq("col", col, t % w);
        check_eq("row", row, t / w);
      end
      if (frame_done) done_cnt++;
      if (timeout) begin to_cnt++; to_cyc = cyc; end
      if (cfg_err) ce_cnt++;
      // Filter stand-in: the first row only fills line buffers, every later input yields one output.
      start = 0; abort = 0;
      flt_out_valid = filt_on && flt_valid && (fin_cnt >= w);
      if (flt_valid) fin_cnt++;
      if (stream_on) begin
        if (scyc == ign_scyc) begin
          start = 1; img_width = DIM_W'(16);
        end
        if (t == abort_t) begin
          abort = 1; src_valid = 1; src_data = DATA_W'($urandom);
          pend_v = 0; stream_on = 0; aborted = 1; end_cyc = cyc + 4;
        end else begin
          v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (scyc % 2 == 0) : 1'($urandom_range(0, 1));
          src_valid = v;
          src_data  = rand_data ? DATA_W'($urandom) : DATA_W'(t);
          pend_v = v; pend_d = src_data;
          if (v) begin
            t++;
            if (t == total) begin
              stream_on = 0; flush_left = w; entry_cyc = cyc + w + 1;
              end_cyc = entry_cyc + (filt_on ? 6 : DRAIN_MAX + 4);
            end
          end else begin
            stall_exp++;
          end
        end
        scyc++;
      end else begin
        src_valid = 1'($urandom_range(0, 1)); src_data = DATA_W'($urandom);
        if (flush_left > 0) begin
          pend_v = 1; pend_d = PAD; flush_left--;
        end else begin
          pend_v = 0;
        end
      end
    end
    src_valid = 0; flt_out_valid = 0;
    if (stream_on) check_eq("stream_end", t, total);
    check_eq("frame_done_cnt", done_cnt, (filt_on && !aborted) ? 1 : 0);
    check_eq("timeout_cnt", to_cnt, (!filt_on && !aborted) ? 1 : 0);
    if (!filt_on && !aborted) check_eq("timeout_cyc", to_cyc, entry_cyc + DRAIN_MAX);
    check_eq("cfg_err_cnt", ce_cnt, 0);
    check_eq("busy_end", busy, 0);
    check_eq("flt_width", flt_width, w);
`ifdef GAUSS_CTRL_STALL_CNT_EN
    check_eq("stall_cnt", stall_cnt, stall_exp);
`else
    check_eq("stall_cnt", stall_cnt, 0);
`endif
    $display("[TB] frame w=%0d h=%0d xfers=%0d stalls=%0d abort=%0d done=%0d timeout=%0d",
             w, h, t, stall_exp, aborted, done_cnt, to_cnt);
  endtask

  task automatic cfg_case(input int w, input int h);
    @(negedge clk);
    start = 1; img_width = DIM_W'(w); img_height = DIM_W'(h); src_valid = 1;
    @(negedge clk);
    start = 0;
    check_eq("cfg_busy_check", busy, 1);
    check_eq("cfg_err_early", cfg_err, 0);
    check_eq("cfg_src_ready_check", src_ready, 0);
    @(negedge clk);
    check_eq("cfg_err_pulse", cfg_err, 1);
    check_eq("cfg_busy_end", busy, 0);
    check_eq("cfg_src_ready", src_ready, 0);
    check_eq("cfg_flt_valid", flt_valid, 0);
    @(negedge clk);
    check_eq("cfg_err_clear", cfg_err, 0);
    check_eq("cfg_flt_valid_after", flt_valid, 0);
    src_valid = 0;
    $display("[TB] cfg w=%0d h=%0d cfg_err_seen", w, h);
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; src_valid = 0; flt_out_valid = 0;
    img_width = '0; img_height = '0; src_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_src_ready", src_ready, 0);
    check_eq("rst_flt_valid", flt_valid, 0);
    check_eq("rst_flt_data", flt_data, 0);
    check_eq("rst_flt_width", flt_width, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_col_row", {col, row}, 0);
    check_eq("rst_pulses", {frame_done, timeout, cfg_err}, 0);
    check_eq("rst_stall_cnt", stall_cnt, 0);
    rst_n = 1;

    run_frame(32, 3, 0, -1, -1, 1, 0);
    run_frame(32, 3, 1, -1, -1, 1, 0);
    cfg_case(0, 3);
    cfg_case(MAX_WIDTH + 1, 3);
    cfg_case(5, 0);
    run_frame(32, 3, 2, -1, 10, 1, 1);
    run_frame(32, 3, 0, 37, -1, 1, 1);
    run_frame(32, 3, 0, -1, -1, 1, 1);
    run_frame(8, 2, 2, 15, -1, 1, 1);
    run_frame(10, 2, 2, -1, -1, 0, 1);
    run_frame(MAX_WIDTH, 1, 0, -1, -1, 1, 1);

    // Asynchronous reset in the middle of streaming.
    @(negedge clk);
    start = 1; img_width = DIM_W'(8); img_height = DIM_W'(2); src_valid = 1;
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check_eq("midrst_flt_valid", flt_valid, 0);
    check_eq("midrst_src_ready", src_ready, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_col_row", {col, row}, 0);
    check_eq("midrst_flt_width", flt_width, 0);
    @(negedge clk);
    rst_n = 1; src_valid = 0;
    $display("[TB] mid-frame reset applied");

    for (int i = 0; i < 6; i++) begin
      run_frame(int'($urandom_range(1, 40)), int'($urandom_range(1, 4)), 2, -1, -1, 1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
